// File: rtl/vga_scan_if.sv
// rtl/vga_scan_if.sv - pixel fetch bus between the scan stage and the image store
// Purpose: carries the downscaled read address out and the 3-bit pixel back.
// Signals:
//   vga_x    [7:0] image column address (scan -> store)
//   vga_y    [7:0] image row address    (scan -> store)
//   vga_dout [2:0] pixel {R,G,B}        (store -> scan), RD_LAT cycles after address
interface vga_scan_if;
  logic [7:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_dout;

  modport master (output vga_x, output vga_y, input vga_dout);
  modport slave  (input vga_x, input vga_y, output vga_dout);
endinterface

// File: rtl/vga_scan.sv
// rtl/vga_scan.sv - VGA timing generator and pixel fetch/expand stage
// Purpose: free-running h/v counters, downscaled image address generation,
// sync/blank delay matched to the image store read latency, 3-bit to 24-bit
// colour expansion, frame-boundary gated display enable.
// Ports:
//   clk_vga, rst           pixel clock, synchronous active-high reset
//   en_vga                 display enable, asynchronous to clk_vga
//   pix (master)           vga_x/vga_y address out, vga_dout pixel in
//   vga_r/g/b [7:0]        DAC colour
//   vga_hs, vga_vs         active-low syncs
//   vga_blank_n            high during active video
//   vga_sync_n             tied low
//   frame_start            one-cycle pulse when counters reach (0,0)
module vga_scan #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2,
  parameter int IMG_W       = 100,
  parameter int IMG_H       = 100,
  parameter int RD_LAT      = 2
) (
  input  logic       clk_vga,
  input  logic       rst,
  input  logic       en_vga,
  vga_scan_if.master pix,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  // Control bits are held until the pixel addressed one cycle after the
  // counter value comes back RD_LAT cycles later.
  localparam int DEPTH   = RD_LAT + 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] IX_LIM   = HW'(IMG_W);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] IY_LIM   = VW'(IMG_H);

  logic [HW-1:0]    h_q, h_d;
  logic [VW-1:0]    v_q, v_d;
  logic [7:0]       x_q, x_d, y_q, y_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d, show_q, show_d;
  logic [DEPTH-1:0] act_p_q, act_p_d, img_p_q, img_p_d;
  logic [DEPTH-1:0] hs_p_q, hs_p_d, vs_p_q, vs_p_d;
  logic [7:0]       r_q, r_d, g_q, g_d, b_q, b_d;
  logic             hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, fs_q, fs_d;

  logic          h_wrap, v_wrap, active, in_img, hs_raw, vs_raw, px_on;
  logic [HW-1:0] ix;
  logic [VW-1:0] iy;

  always_comb begin
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    h_d    = h_wrap ? '0 : h_q + HW'(1);
    v_d    = h_wrap ? (v_wrap ? '0 : v_q + VW'(1)) : v_q;

    active = (h_q < H_ACT) && (v_q < V_ACT);
    hs_raw = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    vs_raw = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    ix     = h_q >> SCALE_SHIFT;
    iy     = v_q >> SCALE_SHIFT;
    in_img = active && (ix < IX_LIM) && (iy < IY_LIM);
    x_d    = in_img ? 8'(ix) : 8'd0;
    y_d    = in_img ? 8'(iy) : 8'd0;

    // Registered so the pulse lines up with the cycle the counters show (0,0).
    fs_d    = h_wrap && v_wrap;

    sync1_d = en_vga;
    sync2_d = sync1_q;
    // Enable is only sampled at the top-left corner so a frame is never torn.
    show_d  = ((h_q == '0) && (v_q == '0)) ? sync2_q : show_q;

    act_p_d = (act_p_q << 1) | DEPTH'(active);
    img_p_d = (img_p_q << 1) | DEPTH'(in_img);
    hs_p_d  = (hs_p_q << 1) | DEPTH'(hs_raw);
    vs_p_d  = (vs_p_q << 1) | DEPTH'(vs_raw);

    // Last stage coincides with vga_dout for the same counter value; in_img
    // already implies active, so this also blanks RGB outside active video.
    px_on   = img_p_q[DEPTH-1] && show_q;
    r_d     = (px_on && pix.vga_dout[2]) ? 8'hFF : 8'h00;
    g_d     = (px_on && pix.vga_dout[1]) ? 8'hFF : 8'h00;
    b_d     = (px_on && pix.vga_dout[0]) ? 8'hFF : 8'h00;
    blank_d = act_p_q[DEPTH-1];
    hs_d    = hs_p_q[DEPTH-1];
    vs_d    = vs_p_q[DEPTH-1];
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      h_q     <= '0;
      v_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      show_q  <= 1'b0;
      act_p_q <= '0;
      img_p_q <= '0;
      hs_p_q  <= '1;
      vs_p_q  <= '1;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      show_q  <= show_d;
      act_p_q <= act_p_d;
      img_p_q <= img_p_d;
      hs_p_q  <= hs_p_d;
      vs_p_q  <= vs_p_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
    end
  end

  assign pix.vga_x   = x_q;
  assign pix.vga_y   = y_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_q;
  assign vga_sync_n  = 1'b0;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_scan.sv
// tb/tb_vga_scan.sv - self-checking bench for vga_scan
module tb_vga_scan;
  localparam int HA = 40, HF = 4, HS = 8, HB = 6;
  localparam int VA = 30, VF = 2, VS = 2, VB = 3;
  localparam int SS = 2, IW = 6, IH = 5, RL = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int L  = RL + 2;

  logic clk = 1'b0;
  logic rst;
  logic en_vga;
  logic [7:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;

  vga_scan_if bus();

  vga_scan #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SCALE_SHIFT(SS), .IMG_W(IW), .IMG_H(IH), .RD_LAT(RL)
  ) dut (
    .clk_vga(clk), .rst(rst), .en_vga(en_vga), .pix(bus),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Image store: 8x8 grid, row-major, read latency RL = 2 registered stages.
  logic [2:0] img [64];
  logic [2:0] m1, m2;
  always @(posedge clk) begin
    if (int'(bus.vga_x) < IW && int'(bus.vga_y) < IH)
      m1 <= img[6'(int'(bus.vga_y) * 8 + int'(bus.vga_x))];
    else
      m1 <= 3'd0;
    m2 <= m1;
  end
  assign bus.vga_dout = m2;

  int vectors = 0;
  int miscompares = 0;
  int k;

  task automatic chk(input string nm, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp_v);
    end
  endtask

  task automatic step();
    @(negedge clk);
    k++;
  endtask

  // Reference: n = cycles since the counters were last forced to (0,0).
  // show for a frame is en_vga as seen two clocks before the frame's first
  // cycle; RGB uses the show value held one cycle before the pin updates.
  int n = 0;
  bit started = 1'b0;
  bit e1, e2, show_m, rgb_show;
  always @(posedge clk) begin
    if (rst) begin
      n <= 0; started <= 1'b1; e1 <= 1'b0; e2 <= 1'b0;
      show_m <= 1'b0; rgb_show <= 1'b0;
    end else if (started) begin
      n <= n + 1;
      e1 <= en_vga;
      e2 <= e1;
      rgb_show <= show_m;
      if (n % FT == 0) show_m <= e2;
    end
  end

  function automatic void decode(input int c, output int hh, output int vv,
                                 output bit act, output bit inimg);
    hh = c % HT;
    vv = (c / HT) % VT;
    act = (hh < HA) && (vv < VA);
    inimg = act && ((hh >> SS) < IW) && ((vv >> SS) < IH);
  endfunction

  int ch, cv, ex, ey, ehs, evs, ebl;
  bit cact, cimg;
  logic [2:0] epx;
  always @(negedge clk) begin
    if (started) begin
      ex = 0; ey = 0;
      if (n >= 1) begin
        decode(n - 1, ch, cv, cact, cimg);
        if (cimg) begin ex = ch >> SS; ey = cv >> SS; end
      end
      ehs = 1; evs = 1; ebl = 0; epx = 3'd0;
      if (n >= L) begin
        decode(n - L, ch, cv, cact, cimg);
        ehs = (ch >= HA + HF && ch < HA + HF + HS) ? 0 : 1;
        evs = (cv >= VA + VF && cv < VA + VF + VS) ? 0 : 1;
        ebl = cact ? 1 : 0;
        if (cimg && rgb_show) epx = img[6'((cv >> SS) * 8 + (ch >> SS))];
      end
      chk("vga_x", bus.vga_x, ex);
      chk("vga_y", bus.vga_y, ey);
      chk("vga_hs", vga_hs, ehs);
      chk("vga_vs", vga_vs, evs);
      chk("vga_blank_n", vga_blank_n, ebl);
      chk("vga_r", vga_r, epx[2] ? 255 : 0);
      chk("vga_g", vga_g, epx[1] ? 255 : 0);
      chk("vga_b", vga_b, epx[0] ? 255 : 0);
      chk("vga_sync_n", vga_sync_n, 0);
      chk("frame_start", frame_start, (n > 0 && n % FT == 0) ? 1 : 0);
    end
  end

  int off, line, hpos, hs_lo1, bl1, blva, vs_lo, nz, first_fall;
  initial begin
    for (int i = 0; i < 64; i++) img[i] = 3'($urandom_range(0, 7));
    img[5] = 3'b101;   // x=5, y=0 -> {x[0], y[0], 1}
    img[0] = 3'b111;   // top-left pixel, white
    rst = 1'b1;
    en_vga = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_hs", vga_hs, 1);
    chk("reset_vs", vga_vs, 1);
    chk("reset_blank_n", vga_blank_n, 0);
    chk("reset_rgb", {vga_r, vga_g, vga_b}, 0);
    rst = 1'b0;
    k = 0;

    while (vga_hs && k < 2 * HT) step();
    chk("first_hs_fall", k, HA + HF + L);
    while (k < 100) step();
    en_vga = 1'b1;
    while (!frame_start && k < 2 * FT) step();
    chk("first_frame_start", k, FT);

    // Frame 1: shown; enable dropped mid-frame must not affect it.
    off = $urandom_range(FT / 4, 3 * FT / 4);
    hs_lo1 = 0; bl1 = 0; blva = 0; vs_lo = 0;
    while (k < 2 * FT + L) begin
      if (k == FT + off) en_vga = 1'b0;
      if (k >= FT + L) begin
        line = (k - FT - L) / HT;
        hpos = (k - FT - L) % HT;
        if (line == 1) begin hs_lo1 += !vga_hs; bl1 += vga_blank_n; end
        if (line == VA) blva += vga_blank_n;
        vs_lo += !vga_vs;
        if (line == 0 && hpos >= 20 && hpos <= 23) begin
          chk("pix_x5_r", vga_r, 255);
          chk("pix_x5_g", vga_g, 0);
          chk("pix_x5_b", vga_b, 255);
        end
        if (line == 0 && hpos == 24) begin
          chk("beyond_img_rgb", {vga_r, vga_g, vga_b}, 0);
          chk("beyond_img_blank_n", vga_blank_n, 1);
        end
      end
      step();
    end
    chk("hs_low_per_line", hs_lo1, HS);
    chk("blank_high_active_line", bl1, HA);
    chk("blank_high_vblank_line", blva, 0);
    chk("vs_low_per_frame", vs_lo, VS * HT);

    // Frame 2: dark; enable raised mid-frame takes effect from frame 3.
    off = $urandom_range(FT / 4, 3 * FT / 4);
    nz = 0;
    while (k < 3 * FT + L) begin
      if (k == 2 * FT + off) en_vga = 1'b1;
      nz += ({vga_r, vga_g, vga_b} != 0) ? 1 : 0;
      step();
    end
    chk("dark_frame_lit_pixels", nz, 0);
    chk("frame3_first_pixel", {vga_r, vga_g, vga_b}, 24'hFFFFFF);

    // One-cycle reset at h=30, v=20 of frame 3.
    while (k < 3 * FT + 20 * HT + 30) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    k = 0;
    chk("midreset_hs", vga_hs, 1);
    chk("midreset_blank_n", vga_blank_n, 0);
    chk("midreset_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("midreset_addr", {bus.vga_x, bus.vga_y}, 0);
    chk("midreset_frame_start", frame_start, 0);
    first_fall = -1;
    while (!frame_start && k < 2 * FT) begin
      step();
      if (!vga_hs && first_fall < 0) first_fall = k;
    end
    chk("midreset_first_hs_fall", first_fall, HA + HF + L);
    chk("midreset_frame_start_at", k, FT);
    repeat (3 * HT) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
